// File: rtl/alu_serial_seq_if.sv
// alu_serial_seq_if: request/acknowledge bus between the serial sequencer and its
// arithmetic core.
//   core_a, core_b  assembled operands (sequencer -> core)
//   core_op         latched opcode (sequencer -> core)
//   core_req        level request, held until acknowledged (sequencer -> core)
//   core_ack        acknowledge; core_result valid in the same cycle (core -> sequencer)
//   core_result     core result (core -> sequencer)
// Modports: master = sequencer side, slave = core side.
interface alu_serial_seq_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 2
);
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [OPW-1:0]   core_op;
    logic             core_req;
    logic             core_ack;
    logic [WIDTH-1:0] core_result;

    modport master (
        output core_a,
        output core_b,
        output core_op,
        output core_req,
        input  core_ack,
        input  core_result
    );

    modport slave (
        input  core_a,
        input  core_b,
        input  core_op,
        input  core_req,
        output core_ack,
        output core_result
    );
endinterface

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: byte-serial front end for a word-wide arithmetic core.
// Collects WIDTH/8 operand bytes for A then B (LSB first), hands both to the core
// over a req/ack bus, then streams the result back one byte per cycle (LSB first).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in          operand byte stream
//   start       operation request (accepted in IDLE, and in ERR when enabled)
//   opcode      operation select, latched with start
//   out, done   result byte stream, done high while out carries a result byte
//   state       current FSM state code (IDLE=0 LOAD_A=1 LOAD_B=2 REQ=3 OUT=4 ERR=7)
//   err         sticky core-timeout flag
//   core        alu_serial_seq_if master modport (its WIDTH/OPW must match this module)
// Build option: define ALU_SEQ_TIMEOUT_EN to bound the core wait to TIMEOUT cycles;
// on expiry the request is dropped, err is set and the FSM parks in ERR. Without it
// the core wait is unbounded and err stays 0.
module alu_serial_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned OPW     = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    output logic [7:0]       out,
    output logic             done,
    output logic [3:0]       state,
    output logic             err,
    alu_serial_seq_if.master core
);
    localparam int unsigned NB = WIDTH / 8;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StLoadA = 4'd1,
        StLoadB = 4'd2,
        StReq   = 4'd3,
        StOut   = 4'd4,
        StErr   = 4'd7
    } state_e;

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [OPW-1:0]   op_q;
    logic             req_q;
    logic             done_q;
    logic             err_q;
    logic [7:0]       out_q;
    logic             last_byte;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q;
`endif

    assign last_byte = (cnt_q == 4'(NB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            op_q     <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            out_q    <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            wait_q   <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= opcode;
                        cnt_q   <= '0;
                        state_q <= StLoadA;
                    end
                end
                StLoadA: begin
                    a_q[8*cnt_q +: 8] <= in;
                    if (last_byte) begin
                        cnt_q   <= '0;
                        state_q <= StLoadB;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StLoadB: begin
                    b_q[8*cnt_q +: 8] <= in;
                    if (last_byte) begin
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        state_q <= StReq;
`ifdef ALU_SEQ_TIMEOUT_EN
                        wait_q  <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StReq: begin
                    if (core.core_ack) begin
                        // Byte 0 goes out on the capture edge so the stream starts
                        // one cycle after the acknowledge.
                        result_q <= core.core_result;
                        out_q    <= core.core_result[7:0];
                        done_q   <= 1'b1;
                        req_q    <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StOut;
                    end
`ifdef ALU_SEQ_TIMEOUT_EN
                    else if (wait_q == TW'(TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= StErr;
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
`endif
                end
                StOut: begin
                    if (last_byte) begin
                        out_q   <= '0;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        out_q <= result_q[8*(cnt_q + 4'd1) +: 8];
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                StErr: begin
                    // A late core_ack is ignored here; only start leaves ERR.
                    if (start) begin
                        op_q    <= opcode;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= StLoadA;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out          = out_q;
    assign done         = done_q;
    assign state        = state_q;
    assign err          = err_q;
    assign core.core_a  = a_q;
    assign core.core_b  = b_q;
    assign core.core_op = op_q;
    assign core.core_req = req_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
module tb_alu_serial_seq;
    localparam int unsigned W   = 32;
    localparam int unsigned NB  = W / 8;
    localparam int unsigned OPW = 2;
    localparam int unsigned TO  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [7:0]     in = '0;
    logic           start = 1'b0;
    logic [OPW-1:0] opcode = '0;
    logic [7:0]     out;
    logic           done;
    logic [3:0]     state;
    logic           err;

    logic [7:0]     in16 = '0;
    logic           start16 = 1'b0;
    logic [OPW-1:0] op16 = '0;
    logic [7:0]     out16;
    logic           done16;
    logic [3:0]     state16;
    logic           err16;

    alu_serial_seq_if #(.WIDTH(W), .OPW(OPW)) cif ();
    alu_serial_seq_if #(.WIDTH(16), .OPW(OPW)) cif16 ();

    alu_serial_seq #(.WIDTH(W), .OPW(OPW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .start(start), .opcode(opcode),
        .out(out), .done(done), .state(state), .err(err), .core(cif)
    );

    alu_serial_seq #(.WIDTH(16), .OPW(OPW), .TIMEOUT(255)) dut16 (
        .clk(clk), .rst_n(rst_n), .in(in16), .start(start16), .opcode(op16),
        .out(out16), .done(done16), .state(state16), .err(err16), .core(cif16)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference core behaviour: what the arithmetic core computes per opcode.
    function automatic logic [W-1:0] model_result(input logic [1:0] op,
                                                  input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // Core stub: acks after ack_delay cycles of core_req, else drives junk results.
    bit             ack_en = 1'b1;
    int             ack_delay = 0;
    bit             stub_fixed = 1'b0;
    logic [W-1:0]   stub_value = '0;
    int             req_cycles = 0;
    int             last_req_len = 0;

    initial begin
        cif.core_ack = 1'b0;
        cif.core_result = '0;
        forever begin
            @(negedge clk);
            if (cif.core_req) req_cycles++;
            else req_cycles = 0;
            if (cif.core_req && ack_en && req_cycles > ack_delay) begin
                cif.core_ack = 1'b1;
                cif.core_result = stub_fixed ? stub_value
                                : model_result(cif.core_op, cif.core_a, cif.core_b);
                last_req_len = req_cycles;
            end else begin
                cif.core_ack = 1'b0;
                cif.core_result = W'($urandom);
            end
        end
    end

    int req16_cycles = 0;
    initial begin
        cif16.core_ack = 1'b0;
        cif16.core_result = '0;
        forever begin
            @(negedge clk);
            if (cif16.core_req) req16_cycles++;
            else req16_cycles = 0;
            cif16.core_ack = cif16.core_req && (req16_cycles > 3);
            cif16.core_result = cif16.core_ack ? 16'h4200 : 16'($urandom);
        end
    end

    // Behavioural model state: expected result bytes and operands of the current op.
    logic [7:0]   exp_q[$];
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [1:0]   m_op = '0;
    bit           m_valid = 1'b0;
    bit           m_err = 1'b0;
    int           done_seen = 0;
    logic [7:0]   obs [8];

    // Single compare process, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) begin
                    if (done_seen < 8) obs[done_seen] = out;
                    done_seen++;
                    if (exp_q.size() == 0) check("unexpected_done", 64'(done), 64'd0);
                    else check("out_byte", 64'(out), 64'(exp_q.pop_front()));
                    check("state_in_out", 64'(state), 64'd4);
                end else begin
                    check("out_zero", 64'(out), 64'd0);
                end
                check("err_flag", 64'(err), 64'(m_err));
                if (cif.core_req && m_valid) begin
                    check("core_a", 64'(cif.core_a), 64'(m_a));
                    check("core_b", 64'(cif.core_b), 64'(m_b));
                    check("core_op", 64'(cif.core_op), 64'(m_op));
                end
            end
        end
    end

    // One operation; called and returns at 1 time unit after a rising edge.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int delay, input bit inject, input int rst_cyc);
        logic [W-1:0] r;
        bit seen_idle;
        r = stub_fixed ? stub_value : model_result(op, a, b);
        ack_delay = delay;
        ack_en = 1'b1;
        m_a = a;
        m_b = b;
        m_op = op;
        m_valid = 1'b1;
        for (int i = 0; i < NB; i++) exp_q.push_back(r[8*i +: 8]);
        done_seen = 0;
        start = 1'b1;
        opcode = op;
        in = 8'($urandom);
        @(posedge clk); #1;
        m_err = 1'b0;
        opcode = 2'($urandom);
        seen_idle = 1'b0;
        for (int k = 1; k <= 3 * NB + delay + 4 && !seen_idle; k++) begin
            if (k <= NB) in = a[8*(k-1) +: 8];
            else if (k <= 2 * NB) in = b[8*(k-NB-1) +: 8];
            else in = 8'($urandom);
            start = inject && (k == NB + 2 || k == 2 * NB + delay + 2);
            @(posedge clk); #1;
            if (rst_cyc != 0 && k == rst_cyc) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rst_out", 64'(out), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_state", 64'(state), 64'd0);
                check("rst_req", 64'(cif.core_req), 64'd0);
                check("rst_core_a", 64'(cif.core_a), 64'd0);
                check("rst_core_op", 64'(cif.core_op), 64'd0);
                exp_q.delete();
                m_valid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (state == 4'd0) begin
                seen_idle = 1'b1;
                check("idle_latency", 64'(k), 64'(3 * NB + 1 + delay));
            end
        end
        start = 1'b0;
        check("idle_reached", 64'(state), 64'd0);
        check("done_cycles", 64'(done_seen), 64'(NB));
        check("bytes_drained", 64'(exp_q.size()), 64'd0);
        check("req_len", 64'(last_req_len), 64'(delay + 1));
    endtask

`ifdef ALU_SEQ_TIMEOUT_EN
    task automatic run_timeout(input logic [W-1:0] a, input logic [W-1:0] b);
        ack_en = 1'b0;
        m_a = a;
        m_b = b;
        m_op = 2'd3;
        m_valid = 1'b1;
        start = 1'b1;
        opcode = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 2 * NB + TO; k++) begin
            if (k <= NB) in = a[8*(k-1) +: 8];
            else if (k <= 2 * NB) in = b[8*(k-NB-1) +: 8];
            else in = 8'($urandom);
            @(posedge clk); #1;
            if (k == 2 * NB + TO - 1) check("to_still_req", 64'(state), 64'd3);
        end
        m_err = 1'b1;
        check("to_state", 64'(state), 64'd7);
        check("to_err", 64'(err), 64'd1);
        check("to_req_drop", 64'(cif.core_req), 64'd0);
        ack_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("to_parked", 64'(state), 64'd7);
    endtask
`endif

    task automatic run16();
        logic [7:0] bytes [4];
        logic [7:0] got[$];
        int req_n;
        bytes = '{8'h00, 8'h3C, 8'h00, 8'h40};
        req_n = 0;
        start16 = 1'b1;
        op16 = 2'd1;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            in16 = (k <= 4) ? bytes[k-1] : 8'h00;
            @(posedge clk); #1;
            if (done16) got.push_back(out16);
            if (cif16.core_req) req_n++;
        end
        check("w16_req_cycles", 64'(req_n), 64'd4);
        check("w16_done_cycles", 64'(got.size()), 64'd2);
        if (got.size() >= 2) begin
            check("w16_byte0", 64'(got[0]), 64'h00);
            check("w16_byte1", 64'(got[1]), 64'h42);
        end
        check("w16_core_a", 64'(cif16.core_a), 64'h3C00);
        check("w16_core_b", 64'(cif16.core_b), 64'h4000);
        check("w16_core_op", 64'(cif16.core_op), 64'd1);
        check("w16_idle", 64'(state16), 64'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(state), 64'd0);
        check("reset_out", 64'(out), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_req", 64'(cif.core_req), 64'd0);
        check("reset_core_a", 64'(cif.core_a), 64'd0);
        check("reset_core_b", 64'(cif.core_b), 64'd0);
        check("reset_core_op", 64'(cif.core_op), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Float example: 1.0 and 2.0 in, core returns 3.0.
        stub_fixed = 1'b1;
        stub_value = 32'h4040_0000;
        run_op(2'd2, 32'h3F80_0000, 32'h4000_0000, 0, 1'b0, 0);
        check("lit_core_a", 64'(cif.core_a), 64'h3F80_0000);
        check("lit_core_b", 64'(cif.core_b), 64'h4000_0000);
        check("lit_core_op", 64'(cif.core_op), 64'd2);
        check("lit_out0", 64'(obs[0]), 64'h00);
        check("lit_out1", 64'(obs[1]), 64'h00);
        check("lit_out2", 64'(obs[2]), 64'h40);
        check("lit_out3", 64'(obs[3]), 64'h40);
        stub_fixed = 1'b0;

        // Pin the reference core: 0x01020304 - 0x00000005 = 0x010202FF.
        run_op(2'd1, 32'h0102_0304, 32'h0000_0005, 2, 1'b0, 0);
        check("pin_out0", 64'(obs[0]), 64'hFF);
        check("pin_out1", 64'(obs[1]), 64'h02);
        check("pin_out2", 64'(obs[2]), 64'h02);
        check("pin_out3", 64'(obs[3]), 64'h01);

        // Start pulses during LOAD_B and OUT must be ignored.
        run_op(2'd0, 32'h1122_3344, 32'h5566_7788, 1, 1'b1, 0);

        for (int i = 0; i < 20; i++)
            run_op(2'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), 0);

        // Reset while the second result byte is on out, then a clean op.
        run_op(2'd2, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 1'b0, 2 * NB + 1 + 2);
        run_op(2'd0, 32'h0000_00FF, 32'h0000_0001, 0, 1'b0, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
        run_timeout(32'hCAFE_0001, 32'h0000_0002);
        run_op(2'd1, 32'h0000_1000, 32'h0000_0001, 1, 1'b0, 0);
`else
        run_op(2'd3, 32'hF0F0_A5A5, 32'hFF00_FF0F, 300, 1'b0, 0);
        check("slow_core_err", 64'(err), 64'd0);
`endif

        run16();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 8 in 16..64; NB = WIDTH/8.
REQ-002 Parameter OPW, default 2, opcode width in bits.
REQ-003 Parameter TIMEOUT, default 255, maximum core-wait cycles (used only with the REQ-029 macro).
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in  input  8  operand byte stream.
REQ-007 start  input  1  operation request, sampled in IDLE (and ERR when configured).
REQ-008 opcode  input  OPW  operation select, latched with start.
REQ-009 out  output  8  result byte stream.
REQ-010 done  output  1  high while out carries a valid result byte.
REQ-011 state  output  4  current FSM state code.
REQ-012 err  output  1  sticky core-timeout flag.
REQ-013 core_a, core_b  output  WIDTH  assembled operands to arithmetic core.
REQ-014 core_op  output  OPW  latched opcode to core.
REQ-015 core_req  output  1  request to core, level, held until acknowledged.
REQ-016 core_ack  input  1  core acknowledge; core_result valid in the same cycle.
REQ-017 core_result  input  WIDTH  core result.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 States/codes: IDLE=0, LOAD_A=1, LOAD_B=2, REQ=3, OUT=4, ERR=7; state SHALL equal the current code.
REQ-020 IDLE: start=1 latches opcode into core_op, clears byte counter, goes to LOAD_A; start=0 stays.
REQ-021 LOAD_A: each cycle samples in into core_a byte[counter], LSB byte first; after NB bytes goes to LOAD_B with counter cleared.
REQ-022 LOAD_B: same for core_b; after NB bytes goes to REQ with core_req=1.
REQ-023 REQ: core_req held 1; on core_ack=1 captures core_result into result register, drops core_req, goes to OUT.
REQ-024 OUT: presents result bytes LSB first, one per cycle, done=1 each of NB cycles; after last byte returns to IDLE with done=0, out=0.
REQ-025 Latency (ack in first REQ cycle): start sampled at edge 0; bytes sampled edges 1..2NB; core_req high after edge 2NB; first out byte after edge 2NB+1; IDLE after edge 3NB+1 (WIDTH=32: 13).
REQ-026 start outside IDLE/ERR SHALL be ignored; in, opcode ignored outside their sampling states.
REQ-027 out SHALL be 0 and done 0 in every state except OUT; core_a/core_b/core_op hold last values until overwritten.

Reset
REQ-028 rst_n low at any time (including mid-load, REQ, OUT) SHALL immediately force IDLE, out=0, done=0, err=0, core_req=0, core_a=core_b=0, core_op=0, counters 0.

Configuration
REQ-029 Macro ALU_SEQ_TIMEOUT_EN defined: a wait counter runs in REQ; if core_ack not seen within TIMEOUT cycles, core_req drops, err=1, state ERR; in ERR, start clears err and proceeds as from IDLE; late core_ack in ERR ignored.
REQ-030 Macro undefined: REQ waits indefinitely, ERR unreachable, err constant 0.

Verification
REQ-031 WIDTH=32, start op=2, A bytes 00,00,80,3F, B bytes 00,00,00,40, core stub acks immediately with 0x40400000 -> core_a=0x3F800000, core_b=0x40000000, core_op=2, out 00,00,40,40 with done=1 on 4 consecutive cycles, IDLE after edge 13.
REQ-032 WIDTH=16, op=1, A 00,3C, B 00,40, stub result 0x4200 after 3-cycle ack delay -> core_req high exactly 4 cycles, out 00,42, done 2 cycles.
REQ-033 start pulsed during LOAD_B and OUT -> no restart, byte order and result unchanged.
REQ-034 rst_n low during second result byte -> out=0, done=0, state=0 immediately; next op runs normally.
REQ-035 ALU_SEQ_TIMEOUT_EN, TIMEOUT=4, stub never acks -> ERR (state=7), err=1 after 4 REQ cycles; new start clears err and completes a normal op.
REQ-036 Macro undefined, stub acks after 300 cycles -> no ERR, err=0, correct result streamed.
